seg7_stream_decoder: RTL and testbench

- Receive-side counterpart of the hex counter/seven-segment display path: samples a 7-bit active-low segment pattern, qualifies it for stability, and decodes it back to a 4-bit hex value.
- Tracks the decoded sequence to infer count direction (up/down, with 0<->F wrap) and counts sequence and code errors.
- Sits on the Clock_Div (1 Hz-class) domain. Used for board-to-board display checking and self-test loopback of the counter.

---
 rtl/seg7_stream_decoder_pkg.sv | 20 ++
 rtl/seg7_stream_decoder_if.sv | 22 ++
 rtl/seg7_stream_decoder_pattern_decode.sv | 19 +
 rtl/seg7_stream_decoder.sv | 141 ++++++++++++++
 tb/tb_seg7_stream_decoder.sv | 145 ++++++++++++++
 5 files changed

// File: rtl/seg7_stream_decoder_pkg.sv
// Shared seven-segment definitions: the pattern table is common to the display
// encoder and this decoder so both ends always agree on the glyphs.
package seg7_stream_decoder_pkg;

    localparam logic [6:0] SEG_OFF = 7'h7F;

    // Active-low g..a patterns, index = hex digit.
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'b0001110, 7'b0000110, 7'b0100001, 7'b1000110,   // F E d C
        7'b0000011, 7'b0001000, 7'b0010000, 7'b0000000,   // b A 9 8
        7'b1111000, 7'b0000010, 7'b0010010, 7'b0011001,   // 7 6 5 4
        7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000    // 3 2 1 0
    };

    typedef enum logic {
        IDLE  = 1'b0,
        TRACK = 1'b1
    } dec_state_e;

endpackage

// File: rtl/seg7_stream_decoder_if.sv
// Segment-pattern input and decoded-status outputs of the stream decoder.
interface seg7_stream_decoder_if #(parameter int ERR_W = 8);
    logic [6:0]       Seg_In;
    logic [3:0]       Value;
    logic             Valid;
    logic             Step;
    logic             Dir_Up;
    logic             Dir_Valid;
    logic             Code_Err;
    logic             Seq_Err;
    logic [ERR_W-1:0] Err_Count;

    modport master (
        output Seg_In,
        input  Value, Valid, Step, Dir_Up, Dir_Valid, Code_Err, Seq_Err, Err_Count
    );

    modport slave (
        input  Seg_In,
        output Value, Valid, Step, Dir_Up, Dir_Valid, Code_Err, Seq_Err, Err_Count
    );
endinterface

// File: rtl/seg7_stream_decoder_pattern_decode.sv
// Combinational reverse lookup of an active-low segment pattern to a hex digit.
module seg7_pattern_decode
    import seg7_stream_decoder_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] digit,
    output logic       legal
);
    always_comb begin
        digit = 4'd0;
        legal = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (seg == SEG_TABLE[i]) begin
                digit = 4'(i);
                legal = 1'b1;
            end
        end
    end
endmodule

// File: rtl/seg7_stream_decoder.sv
// Qualifies a sampled segment pattern for stability, decodes it and tracks the
// digit sequence for count direction and error accounting.
module seg7_stream_decoder
    import seg7_stream_decoder_pkg::*;
#(
    parameter int STABLE_CYCLES = 2,
    parameter int ERR_W         = 8
) (
    input  logic                  Clock_Div,
    input  logic                  Reset,
    seg7_stream_decoder_if.slave  bus
);
    localparam logic [3:0] CNT_MAX = 4'(STABLE_CYCLES);

    logic [6:0]       seg_q;
    logic [3:0]       stable_cnt;
    logic             accepted;
    logic             match, accept;
    logic [3:0]       digit;
    logic             legal;

    dec_state_e       state_q, state_d;
    logic [3:0]       value_q, value_d;
    logic             valid_q, valid_d;
    logic             dir_up_q, dir_up_d;
    logic             dir_valid_q, dir_valid_d;
    logic             step_q, step_d;
    logic             code_err_q, code_err_d;
    logic             seq_err_q, seq_err_d;
    logic             err_inc;
    logic [ERR_W-1:0] err_q;
    logic [3:0]       value_inc, value_dec;

    // The new sample is compared against the previous one held in seg_q.
    assign match  = (bus.Seg_In == seg_q);
    assign accept = match && (stable_cnt == CNT_MAX - 4'd1) && !accepted;

    always_ff @(posedge Clock_Div or negedge Reset) begin
        if (!Reset) begin
            seg_q      <= SEG_OFF;
            stable_cnt <= 4'd0;
            accepted   <= 1'b0;
        end else begin
            seg_q <= bus.Seg_In;
            if (match) begin
                if (stable_cnt != CNT_MAX)
                    stable_cnt <= stable_cnt + 4'd1;
                if (accept)
                    accepted <= 1'b1;
            end else begin
                stable_cnt <= 4'd0;
                accepted   <= 1'b0;
            end
        end
    end

    seg7_pattern_decode u_decode (
        .seg   (seg_q),
        .digit (digit),
        .legal (legal)
    );

    assign value_inc = value_q + 4'd1;
    assign value_dec = value_q - 4'd1;

    always_comb begin
        state_d     = state_q;
        value_d     = value_q;
        valid_d     = valid_q;
        dir_up_d    = dir_up_q;
        dir_valid_d = dir_valid_q;
        step_d      = 1'b0;
        code_err_d  = 1'b0;
        seq_err_d   = 1'b0;
        err_inc     = 1'b0;
        if (accept) begin
            if (!legal) begin
                code_err_d = 1'b1;
                err_inc    = 1'b1;
            end else begin
                value_d = digit;
                case (state_q)
                    IDLE: begin
                        valid_d = 1'b1;
                        state_d = TRACK;
                    end
                    TRACK: begin
                        if (digit == value_inc) begin
                            step_d      = 1'b1;
                            dir_up_d    = 1'b1;
                            dir_valid_d = 1'b1;
                        end else if (digit == value_dec) begin
                            step_d      = 1'b1;
                            dir_up_d    = 1'b0;
                            dir_valid_d = 1'b1;
                        end else if (digit != value_q) begin
                            seq_err_d = 1'b1;
                            err_inc   = 1'b1;
                        end
                    end
                    default: state_d = IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge Clock_Div or negedge Reset) begin
        if (!Reset) begin
            state_q     <= IDLE;
            value_q     <= 4'd0;
            valid_q     <= 1'b0;
            dir_up_q    <= 1'b0;
            dir_valid_q <= 1'b0;
            step_q      <= 1'b0;
            code_err_q  <= 1'b0;
            seq_err_q   <= 1'b0;
            err_q       <= '0;
        end else begin
            state_q     <= state_d;
            value_q     <= value_d;
            valid_q     <= valid_d;
            dir_up_q    <= dir_up_d;
            dir_valid_q <= dir_valid_d;
            step_q      <= step_d;
            code_err_q  <= code_err_d;
            seq_err_q   <= seq_err_d;
            if (err_inc && (err_q != '1))
                err_q <= err_q + 1'b1;
        end
    end

    assign bus.Value     = value_q;
    assign bus.Valid     = valid_q;
    assign bus.Step      = step_q;
    assign bus.Dir_Up    = dir_up_q;
    assign bus.Dir_Valid = dir_valid_q;
    assign bus.Code_Err  = code_err_q;
    assign bus.Seq_Err   = seq_err_q;
    assign bus.Err_Count = err_q;

endmodule

// File: tb/tb_seg7_stream_decoder.sv
// Directed bench for the segment stream decoder with hand-derived expectations.
module tb_seg7_stream_decoder;
    localparam int ERR_W = 8;

    logic Clock_Div = 1'b0;
    logic Reset     = 1'b0;
    int   errors    = 0;
    int   checks    = 0;

    // Active-low g..a glyphs, written out independently of the design package.
    logic [6:0] pat [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };
    logic [6:0] bad = 7'b1111111;

    seg7_stream_decoder_if #(.ERR_W(ERR_W)) bus ();

    seg7_stream_decoder #(.STABLE_CYCLES(2), .ERR_W(ERR_W)) dut (
        .Clock_Div (Clock_Div),
        .Reset     (Reset),
        .bus       (bus.slave)
    );

    always #5 Clock_Div = ~Clock_Div;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Present a pattern for n rising edges; returns 1 time unit after the last edge.
    task automatic edges(input logic [6:0] p, input int n);
        bus.Seg_In = p;
        repeat (n) begin
            @(posedge Clock_Div);
            #1;
        end
    endtask

    // Hold a new pattern 4 edges; pulses {Step,Code_Err,Seq_Err} expected after edge 3 only.
    task automatic put(input logic [6:0] p, input logic [2:0] exp_pulse, input string tag);
        edges(p, 3);
        chk({tag, " pulse"}, {29'd0, bus.Step, bus.Code_Err, bus.Seq_Err}, {29'd0, exp_pulse});
        edges(p, 1);
        chk({tag, " pulse_end"}, {29'd0, bus.Step, bus.Code_Err, bus.Seq_Err}, 32'd0);
    endtask

    initial begin
        bus.Seg_In = 7'h7F;
        #12;
        chk("rst value", bus.Value, 0);
        chk("rst valid", bus.Valid, 0);
        chk("rst pulses", {bus.Step, bus.Code_Err, bus.Seq_Err}, 0);
        chk("rst dir", {bus.Dir_Up, bus.Dir_Valid}, 0);
        chk("rst errcnt", bus.Err_Count, 0);

        // First digit: accepted on the third edge, through the IDLE path.
        @(negedge Clock_Div);
        Reset      = 1'b1;
        bus.Seg_In = pat[0];
        edges(pat[0], 2);
        chk("early valid", bus.Valid, 0);
        edges(pat[0], 1);
        chk("first value", bus.Value, 0);
        chk("first valid", bus.Valid, 1);
        chk("first step", bus.Step, 0);
        chk("first errcnt", bus.Err_Count, 0);
        edges(pat[0], 1);

        // Count up 1..F then wrap to 0.
        for (int d = 1; d <= 16; d++) begin
            put(pat[d % 16], 3'b100, "up");
            chk("up value", bus.Value, d % 16);
            chk("up dir", {bus.Dir_Up, bus.Dir_Valid}, 2'b11);
        end
        chk("up errcnt", bus.Err_Count, 0);

        // Count down 0 -> F -> E ... -> 3.
        put(pat[15], 3'b100, "down wrap");
        chk("down wrap value", bus.Value, 15);
        chk("down dir", {bus.Dir_Up, bus.Dir_Valid}, 2'b01);
        for (int d = 14; d >= 3; d--) begin
            put(pat[d], 3'b100, "down");
            chk("down value", bus.Value, d);
        end
        chk("down dir end", {bus.Dir_Up, bus.Dir_Valid}, 2'b01);

        // One-sample glitch, then back to the same digit.
        edges(7'b0000000, 1);
        chk("glitch pulse", {bus.Step, bus.Code_Err, bus.Seq_Err}, 0);
        put(pat[3], 3'b000, "same");
        chk("same value", bus.Value, 3);
        chk("same errcnt", bus.Err_Count, 0);

        put(pat[9], 3'b001, "seqerr");
        chk("seqerr value", bus.Value, 9);
        chk("seqerr errcnt", bus.Err_Count, 1);
        chk("seqerr dir held", {bus.Dir_Up, bus.Dir_Valid}, 2'b01);

        put(bad, 3'b010, "codeerr");
        chk("codeerr value", bus.Value, 9);
        chk("codeerr errcnt", bus.Err_Count, 2);

        // 300 error events drive the counter well past its ceiling.
        for (int i = 0; i < 300; i++) begin
            if (i % 2 == 1)
                put(bad, 3'b010, "sat code");
            else
                put((i % 4 == 0) ? pat[3] : pat[9], 3'b001, "sat seq");
        end
        chk("sat errcnt", bus.Err_Count, 255);
        chk("sat value", bus.Value, 9);

        // Reset while a new pattern is one sample into qualification.
        edges(pat[5], 2);
        chk("mid no accept", bus.Value, 9);
        #2;
        Reset = 1'b0;
        #1;
        chk("mid rst value", bus.Value, 0);
        chk("mid rst valid", bus.Valid, 0);
        chk("mid rst dir", {bus.Dir_Up, bus.Dir_Valid}, 0);
        chk("mid rst errcnt", bus.Err_Count, 0);
        bus.Seg_In = pat[4];
        @(negedge Clock_Div);
        Reset = 1'b1;
        edges(pat[4], 3);
        chk("post rst value", bus.Value, 4);
        chk("post rst valid", bus.Valid, 1);
        chk("post rst pulses", {bus.Step, bus.Code_Err, bus.Seq_Err}, 0);
        chk("post rst dirvalid", bus.Dir_Valid, 0);
        edges(pat[4], 1);
        put(pat[5], 3'b100, "post rst step");
        chk("post rst dir", {bus.Dir_Up, bus.Dir_Valid}, 2'b11);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
